// File: rtl/mult_array.sv
// N-channel pipelined multiplier with optional signed mode, rounding right shift and
// per-channel output saturation. A valid bit travels with the data through the pipeline.
module mult_array #(
  parameter int CH     = 3,
  parameter int WA     = 6,
  parameter int WB     = 8,
  parameter int WO     = 14,
  parameter int SHIFT  = 0,
  parameter int ROUND  = 0,
  parameter int SIGNED = 0,
  parameter int PIPE   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             i_valid,
  input  logic [CH*WA-1:0] i_dataa,
  input  logic [CH*WB-1:0] i_datab,
  input  logic             i_ovf_clr,
  output logic [CH*WO-1:0] o_data,
  output logic             o_valid,
  output logic [CH-1:0]    o_ovf,
  output logic [CH-1:0]    o_ovf_sticky
);

  localparam int WP = WA + WB;
  // Guard width: holds the rounded product and both clamp limits without wrapping.
  localparam int WC = ((WP + 2) > (WO + 2)) ? (WP + 2) : (WO + 2);
  localparam int RSH = (SHIFT > 0) ? (SHIFT - 1) : 0;
  localparam logic signed [WC-1:0] ONE  = 1;
  localparam logic signed [WC-1:0] MAXV = (SIGNED != 0) ? ((ONE <<< (WO - 1)) - ONE)
                                                        : ((ONE <<< WO) - ONE);
  localparam logic signed [WC-1:0] MINV = (SIGNED != 0) ? -(ONE <<< (WO - 1)) : '0;
  localparam logic signed [WC-1:0] RND  = ((ROUND != 0) && (SHIFT > 0)) ? (ONE <<< RSH) : '0;

  logic [PIPE-1:0]    v_q;
  logic [PIPE-1:0]    v_d;
  logic [CH*WP-1:0]   prod_d;
  logic [CH*WP-1:0]   last_prod;
  logic               last_vin;
  logic [CH*WO-1:0]   res_d;
  logic [CH-1:0]      ovf_d;
  logic [CH*WO-1:0]   data_q;
  logic [CH-1:0]      ovf_q;
  logic [CH-1:0]      sticky_q;
  logic [CH-1:0]      sticky_d;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic signed [WP-1:0] a_w;
      logic signed [WP-1:0] b_w;
      logic signed [WP-1:0] p_w;
      logic        [WP-1:0] lp;
      logic signed [WC-1:0] p_ext;
      logic signed [WC-1:0] r_sh;
      logic        [WO-1:0] res_c;
      logic                 ovf_c;

      always_comb begin
        if (SIGNED != 0) begin
          a_w = WP'($signed(i_dataa[gi*WA +: WA]));
          b_w = WP'($signed(i_datab[gi*WB +: WB]));
        end else begin
          a_w = WP'(i_dataa[gi*WA +: WA]);
          b_w = WP'(i_datab[gi*WB +: WB]);
        end
      end

      // The full product fits exactly in WP bits in either signedness.
      assign p_w = a_w * b_w;
      assign prod_d[gi*WP +: WP] = p_w;
      assign lp = last_prod[gi*WP +: WP];

      always_comb begin
        if (SIGNED != 0) p_ext = WC'($signed(lp));
        else             p_ext = WC'(lp);
        r_sh  = (p_ext + RND) >>> SHIFT;
        res_c = r_sh[WO-1:0];
        ovf_c = 1'b0;
        if (r_sh > MAXV) begin
          res_c = MAXV[WO-1:0];
          ovf_c = 1'b1;
        end else if (r_sh < MINV) begin
          res_c = MINV[WO-1:0];
          ovf_c = 1'b1;
        end
      end

      assign res_d[gi*WO +: WO] = res_c;
      assign ovf_d[gi]          = ovf_c;
    end

    // Products ride through PIPE-1 stages; round/saturate happens on entry to the last stage.
    if (PIPE > 1) begin : g_deep
      logic [CH*WP-1:0] prod_q [PIPE-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < PIPE - 1; k++) prod_q[k] <= '0;
        end else if (clk_en) begin
          if (i_valid) prod_q[0] <= prod_d;
          for (int k = 1; k < PIPE - 1; k++) begin
            if (v_q[k-1]) prod_q[k] <= prod_q[k-1];
          end
        end
      end

      assign last_prod = prod_q[PIPE-2];
      assign last_vin  = v_q[PIPE-2];
    end else begin : g_flat
      assign last_prod = prod_d;
      assign last_vin  = i_valid;
    end
  endgenerate

  assign v_d      = (v_q << 1) | PIPE'(i_valid);
  assign sticky_d = (sticky_q & ~{CH{i_ovf_clr}}) | ((clk_en && last_vin) ? ovf_d : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q      <= '0;
      data_q   <= '0;
      ovf_q    <= '0;
      sticky_q <= '0;
    end else begin
      if (clk_en) begin
        v_q <= v_d;
        if (last_vin) begin
          data_q <= res_d;
          ovf_q  <= ovf_d;
        end
      end
      sticky_q <= sticky_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = v_q[PIPE-1];
  assign o_ovf        = ovf_q;
  assign o_ovf_sticky = sticky_q;

endmodule
